prbs9_ber_checker: RTL and testbench
====================================

Name: prbs9_ber_checker

Overview:
- Receive-end counterpart of the PRBS9 bit source in the QPSK link: takes one hard-decided bit per symbol strobe from the receiver slicer of one channel (I or Q).
- Finds the channel latency against a local PRBS9 reference.
- Once aligned, accumulates the compared-bit and error-bit counts for BER readout via VIO/ILA.
- One instance per channel inside the communication system, between slicer output and debug probes.

Parameters:
- SEED, 9'h1AA, PRBS9 reference initial state; must equal the transmitter seed; must be non-zero.
- LAT_W, 9, latency search width; candidate delays 0..2^LAT_W-1; depth of the reference history register.
- WIN, 128, aligned bits that must match with zero errors before declaring lock.
- CNT_W, 64, width of bit and error accumulators.
- LOSS_ERR, 32, errors within one WIN-bit window, while locked, that force re-search.

Ports:
- clk, input, 1, system clock.
- i_reset, input, 1, synchronous active-high reset.
- i_enable, input, 1, run enable; deasserted holds all state except reset.
- i_valid, input, 1, one-cycle strobe: i_bit is a new received decision.
- i_bit, input, 1, received hard bit (slicer sign).
- i_clear, input, 1, synchronous restart of search and counters; reference generator keeps running.
- o_locked, output, 1, alignment found.
- o_latency, output, LAT_W, delay (in valid strobes) currently tested or locked.
- o_bit_cnt, output, CNT_W, bits compared while locked.
- o_err_cnt, output, CNT_W, errors while locked.

Behaviour:
- Reset: o_locked=0, o_latency=0, o_bit_cnt=0, o_err_cnt=0; state=SEARCH; reference LFSR=SEED; history register=0; window counters=0.
- Everything advances only on cycles with i_enable=1 and i_valid=1 ("strobe"); other cycles hold.
- Reference generator: Fibonacci LFSR x^9+x^5+1, new bit = s[8]^s[4], output bit = s[8], period 511. Shifts once per strobe.
- History: ref_hist shifts the generator output in at index 0 on each strobe. Comparison bit on a strobe = ref_hist[o_latency] sampled before the shift, so latency 0 means rx equals the previous strobe's reference bit.
- err = i_bit ^ ref_hist[o_latency].

State SEARCH:
- win_cnt counts strobes.
- Any err: o_latency <= o_latency+1 (wraps 2^LAT_W-1 -> 0); win_cnt <= 0.
- win_cnt reaching WIN-1 with no err: go to LOCKED, o_locked <= 1 on the next clock edge, counters start from 0.

State LOCKED:
- Each strobe: o_bit_cnt += 1, o_err_cnt += err. Both saturate at all-ones; o_err_cnt never exceeds o_bit_cnt.
- Window error counter per WIN strobes: if errors reach LOSS_ERR within the window, go to SEARCH with o_locked <= 0 and o_latency <= o_latency+1.
- o_bit_cnt/o_err_cnt keep their values across loss of lock (cumulative) until i_clear or reset.

Other rules:
- i_clear, registered priority below i_reset and above strobe: state=SEARCH, o_latency=0, counters and window=0, LFSR/history untouched. Applies even if i_valid is high the same cycle; that strobe is not compared.
- Reset mid-search or mid-lock: immediate return to reset values on the next edge.
- Output timing: all outputs registered; counter updates visible one clock after the strobe.

Decomposition:
- Shared package qpsk_pkg: PRBS9 polynomial taps, default seed (shared with the transmitter PRBS), state encoding constants ST_SEARCH/ST_LOCKED.
- Sub-module prbs9_gen: LFSR with enable and seed, reused by the transmitter.
- Checker FSM, history and counters stay in the top of this block.

Test Plan:
- Zero delay: drive i_bit from an identical prbs9_gen delayed 1 strobe, valid every 4th clock -> o_latency=0, o_locked=1 after 128 strobes; after 1000 more strobes o_bit_cnt=1000, o_err_cnt=0.
- Delay 37: same source delayed 38 strobes -> o_locked=1 with o_latency=37; o_err_cnt=0.
- Injected errors: after lock, invert 1 bit in every 100 for 10000 strobes -> o_bit_cnt=10000, o_err_cnt=100, o_locked stays 1.
- Loss of lock: after lock, change the source delay by 5 -> o_locked falls within 128 strobes, relocks with o_latency = old+5 (mod 512); o_bit_cnt retains the pre-loss value plus new counts.
- i_clear pulse during LOCKED with simultaneous i_valid -> next cycle o_locked=0, o_latency=0, counts=0; relock at the same latency after 128+latency strobes.
- i_reset for one cycle mid-lock, and i_enable=0 for 50 cycles with strobes present -> reset values on the next edge; no count change while disabled.

Source files
------------

// File: rtl/qpsk_pkg.sv
// Shared QPSK link definitions: PRBS9 polynomial taps, default seed and BER checker states.
package qpsk_pkg;

    localparam int PRBS9_TAP_HI = 8;
    localparam int PRBS9_TAP_LO = 4;
    localparam logic [8:0] PRBS9_DEFAULT_SEED = 9'h1AA;

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } ber_state_t;

    // One step of the x^9+x^5+1 Fibonacci LFSR; the output bit is s[8] before the step.
    function automatic logic [8:0] prbs9_next(input logic [8:0] s);
        return {s[7:0], s[PRBS9_TAP_HI] ^ s[PRBS9_TAP_LO]};
    endfunction

endpackage

// File: rtl/prbs9_gen.sv
// PRBS9 source (x^9+x^5+1, period 511) shared by the transmitter and the receive-side checker.
// SEED must be non-zero, otherwise the register stays stuck at zero.
module prbs9_gen
    import qpsk_pkg::*;
#(
    parameter logic [8:0] SEED = PRBS9_DEFAULT_SEED
) (
    input  logic clk,
    input  logic i_reset,
    input  logic i_enable,
    output logic o_bit
);

    logic [8:0] lfsr;

    // Load the seed on reset, advance one position per enabled cycle.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            lfsr <= SEED;
        end else if (i_enable) begin
            lfsr <= prbs9_next(lfsr);
        end
    end

    assign o_bit = lfsr[PRBS9_TAP_HI];

endmodule

// File: rtl/prbs9_ber_checker.sv
// PRBS9 bit-error-rate checker: searches the channel latency against a local reference,
// then accumulates compared-bit and error-bit counts while aligned.
module prbs9_ber_checker
    import qpsk_pkg::*;
#(
    parameter logic [8:0] SEED     = PRBS9_DEFAULT_SEED,
    parameter int         LAT_W    = 9,
    parameter int         WIN      = 128,
    parameter int         CNT_W    = 64,
    parameter int         LOSS_ERR = 32
) (
    input  logic             clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_valid,
    input  logic             i_bit,
    input  logic             i_clear,
    output logic             o_locked,
    output logic [LAT_W-1:0] o_latency,
    output logic [CNT_W-1:0] o_bit_cnt,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam int DEPTH = 1 << LAT_W;
    localparam int WC_W  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int WE_W  = (LOSS_ERR > 1) ? $clog2(LOSS_ERR + 1) : 1;
    localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WIN - 1);
    localparam logic [WE_W:0]   LOSS_LIM = (WE_W + 1)'(LOSS_ERR);

    ber_state_t       state;
    ber_state_t       state_nxt;
    logic [DEPTH-1:0] ref_hist;
    logic             ref_bit;
    logic             strobe;
    logic             cmp_bit;
    logic             err;
    logic [WC_W-1:0]  win_cnt;
    logic [WE_W-1:0]  win_err;
    logic [WE_W:0]    err_sum;
    logic             win_end;
    logic             lock_now;
    logic             lose_now;

    assign strobe  = i_enable & i_valid;
    assign cmp_bit = ref_hist[o_latency];
    assign err     = i_bit ^ cmp_bit;
    assign win_end = (win_cnt == WIN_LAST);
    assign err_sum = {1'b0, win_err} + {{WE_W{1'b0}}, err};

    // The reference runs on every strobe, including a strobe that coincides with a clear.
    prbs9_gen #(
        .SEED(SEED)
    ) u_ref_gen (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_enable (strobe),
        .o_bit    (ref_bit)
    );

    // Delay line of past reference bits; index k holds the reference from k+1 strobes ago.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            ref_hist <= '0;
        end else if (strobe) begin
            ref_hist <= {ref_hist[DEPTH-2:0], ref_bit};
        end
    end

    // Next-state decision: lock after a clean window, drop lock on too many window errors.
    always_comb begin
        state_nxt = state;
        lock_now  = 1'b0;
        lose_now  = 1'b0;
        case (state)
            ST_SEARCH: begin
                if (!err && win_end) begin
                    state_nxt = ST_LOCKED;
                    lock_now  = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (err_sum >= LOSS_LIM) begin
                    state_nxt = ST_SEARCH;
                    lose_now  = 1'b1;
                end
            end
            default: state_nxt = ST_SEARCH;
        endcase
    end

    // State register; a clear outranks the strobe of the same cycle.
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state <= ST_SEARCH;
        end else if (i_enable && i_clear) begin
            state <= ST_SEARCH;
        end else if (strobe) begin
            state <= state_nxt;
        end
    end

    // Latency stepping, window bookkeeping and the saturating BER accumulators.
    always_ff @(posedge clk) begin
        if (i_reset || (i_enable && i_clear)) begin
            o_locked  <= 1'b0;
            o_latency <= '0;
            o_bit_cnt <= '0;
            o_err_cnt <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
        end else if (strobe) begin
            if (state == ST_SEARCH) begin
                if (err) begin
                    o_latency <= o_latency + LAT_W'(1);
                    win_cnt   <= '0;
                end else if (lock_now) begin
                    o_locked <= 1'b1;
                    win_cnt  <= '0;
                    win_err  <= '0;
                end else begin
                    win_cnt <= win_cnt + WC_W'(1);
                end
            end else begin
                if (!(&o_bit_cnt)) begin
                    o_bit_cnt <= o_bit_cnt + CNT_W'(1);
                end
                if (err && !(&o_err_cnt)) begin
                    o_err_cnt <= o_err_cnt + CNT_W'(1);
                end
                if (lose_now) begin
                    o_locked  <= 1'b0;
                    o_latency <= o_latency + LAT_W'(1);
                    win_cnt   <= '0;
                    win_err   <= '0;
                end else if (win_end) begin
                    win_cnt <= '0;
                    win_err <= '0;
                end else begin
                    win_cnt <= win_cnt + WC_W'(1);
                    win_err <= err_sum[WE_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs9_ber_checker.sv
// Self-checking bench for prbs9_ber_checker: a delayed PRBS9 source drives the checker,
// and a sequence-level reference model predicts lock, latency and counts after every strobe.
module tb_prbs9_ber_checker;

    localparam logic [8:0] TB_SEED = 9'h1AA;
    localparam int LAT_W    = 9;
    localparam int WIN      = 128;
    localparam int CNT_W    = 64;
    localparam int LOSS_ERR = 32;
    localparam int PERIOD   = 511;

    logic             clk;
    logic             i_reset;
    logic             i_enable;
    logic             i_valid;
    logic             i_bit;
    logic             i_clear;
    logic             o_locked;
    logic [LAT_W-1:0] o_latency;
    logic [CNT_W-1:0] o_bit_cnt;
    logic [CNT_W-1:0] o_err_cnt;

    int n_cmp;
    int n_bad;

    bit xs [0:PERIOD-1];
    int src_delay;

    int               m_k;
    bit               m_locked;
    logic [LAT_W-1:0] m_lat;
    logic [CNT_W-1:0] m_bits;
    logic [CNT_W-1:0] m_errs;
    int               m_win;
    int               m_werr;

    prbs9_ber_checker #(
        .SEED     (TB_SEED),
        .LAT_W    (LAT_W),
        .WIN      (WIN),
        .CNT_W    (CNT_W),
        .LOSS_ERR (LOSS_ERR)
    ) dut (
        .clk       (clk),
        .i_reset   (i_reset),
        .i_enable  (i_enable),
        .i_valid   (i_valid),
        .i_bit     (i_bit),
        .i_clear   (i_clear),
        .o_locked  (o_locked),
        .o_latency (o_latency),
        .o_bit_cnt (o_bit_cnt),
        .o_err_cnt (o_err_cnt)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a hung run.
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference sequence from the recurrence a[n] = a[n-9] ^ a[n-5], seeded from the register image.
    task automatic build_sequence();
        for (int j = 0; j < 9; j++) xs[8-j] = TB_SEED[j];
        for (int n = 9; n < PERIOD; n++) xs[n] = xs[n-9] ^ xs[n-5];
    endtask

    function automatic bit ref_at(input int n);
        return xs[n % PERIOD];
    endfunction

    function automatic bit src_bit();
        return (m_k >= src_delay) ? ref_at(m_k - src_delay) : 1'b0;
    endfunction

    task automatic model_reset();
        m_k      = 0;
        m_locked = 1'b0;
        m_lat    = '0;
        m_bits   = '0;
        m_errs   = '0;
        m_win    = 0;
        m_werr   = 0;
    endtask

    task automatic model_clear();
        m_locked = 1'b0;
        m_lat    = '0;
        m_bits   = '0;
        m_errs   = '0;
        m_win    = 0;
        m_werr   = 0;
        m_k++;
    endtask

    task automatic model_strobe(input bit rx);
        int idx;
        bit cmp;
        bit e;
        idx = m_k - 1 - int'(m_lat);
        cmp = (idx >= 0) ? ref_at(idx) : 1'b0;
        e   = rx ^ cmp;
        if (!m_locked) begin
            if (e) begin
                m_lat = m_lat + 1'b1;
                m_win = 0;
            end else if (m_win == WIN - 1) begin
                m_locked = 1'b1;
                m_win    = 0;
                m_werr   = 0;
            end else begin
                m_win++;
            end
        end else begin
            if (m_bits != '1) m_bits = m_bits + 1'b1;
            if (e && m_errs != '1) m_errs = m_errs + 1'b1;
            if (m_werr + int'(e) >= LOSS_ERR) begin
                m_locked = 1'b0;
                m_lat    = m_lat + 1'b1;
                m_win    = 0;
                m_werr   = 0;
            end else if (m_win == WIN - 1) begin
                m_win  = 0;
                m_werr = 0;
            end else begin
                m_win++;
                m_werr += int'(e);
            end
        end
        m_k++;
    endtask

    // One strobe of the delayed source (optionally inverted), then gap-1 idle clocks; ends on a negedge.
    task automatic drive_strobe(input bit inv, input int gap);
        bit rx;
        rx      = src_bit() ^ inv;
        i_valid = 1'b1;
        i_bit   = rx;
        @(posedge clk);
        model_strobe(rx);
        @(negedge clk);
        i_valid = 1'b0;
        i_bit   = 1'($urandom);
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic pulse_reset();
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        i_reset = 1'b0;
        model_reset();
        n_cmp++;
        if (o_locked !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL reset.locked: got %b want 0", o_locked);
        end
        n_cmp++;
        if (o_latency !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset.latency: got %0d want 0", o_latency);
        end
        n_cmp++;
        if (o_bit_cnt !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset.bit_cnt: got %0d want 0", o_bit_cnt);
        end
        n_cmp++;
        if (o_err_cnt !== '0) begin
            n_bad++;
            $display("[TB] FAIL reset.err_cnt: got %0d want 0", o_err_cnt);
        end
    endtask

    task automatic test_zero_delay();
        src_delay = 1;
        for (int i = 0; i < WIN; i++) begin
            drive_strobe(1'b0, 4);
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL zero_delay.track strobe %0d: got %h want %h", m_k,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        n_cmp++;
        if ({o_locked, o_latency} !== {1'b1, 9'd0}) begin
            n_bad++;
            $display("[TB] FAIL zero_delay.lock: got locked=%b lat=%0d want locked=1 lat=0", o_locked, o_latency);
        end
        for (int i = 0; i < 1000; i++) begin
            drive_strobe(1'b0, int'($urandom_range(1, 4)));
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL zero_delay.track strobe %0d: got %h want %h", m_k,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        n_cmp++;
        if (o_bit_cnt !== 64'd1000 || o_err_cnt !== 64'd0) begin
            n_bad++;
            $display("[TB] FAIL zero_delay.counts: got bits=%0d errs=%0d want bits=1000 errs=0", o_bit_cnt, o_err_cnt);
        end
    endtask

    task automatic test_delay_37();
        pulse_reset();
        src_delay = 38;
        for (int i = 0; i < 400; i++) begin
            drive_strobe(1'b0, int'($urandom_range(1, 3)));
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL delay_37.track strobe %0d: got %h want %h", m_k,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        n_cmp++;
        if ({o_locked, o_latency} !== {1'b1, 9'd37} || o_err_cnt !== 64'd0) begin
            n_bad++;
            $display("[TB] FAIL delay_37.lock: got locked=%b lat=%0d errs=%0d want locked=1 lat=37 errs=0",
                     o_locked, o_latency, o_err_cnt);
        end
    endtask

    task automatic test_injected_errors();
        logic [CNT_W-1:0] base_bits;
        logic [CNT_W-1:0] base_errs;
        int off;
        bit stayed_locked;
        base_bits     = m_bits;
        base_errs     = m_errs;
        off           = int'($urandom_range(0, 99));
        stayed_locked = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            drive_strobe((i % 100) == off, int'($urandom_range(1, 3)));
            if (o_locked !== 1'b1) stayed_locked = 1'b0;
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL injected.track strobe %0d: got %h want %h", m_k,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        n_cmp++;
        if (o_bit_cnt !== base_bits + 64'd10000 || o_err_cnt !== base_errs + 64'd100) begin
            n_bad++;
            $display("[TB] FAIL injected.counts: got bits=%0d errs=%0d want bits=%0d errs=%0d",
                     o_bit_cnt, o_err_cnt, base_bits + 64'd10000, base_errs + 64'd100);
        end
        n_cmp++;
        if (stayed_locked !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL injected.stay_locked: got %b want 1", stayed_locked);
        end
    endtask

    task automatic test_loss_of_lock();
        logic [CNT_W-1:0] base_bits;
        bit seen_unlock;
        for (int i = 0; i < 2 * WIN && m_win != 0; i++) begin
            drive_strobe(1'b0, 1);
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL loss.track strobe %0d: got %h want %h", m_k,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        src_delay   = 43;
        base_bits   = m_bits;
        seen_unlock = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            drive_strobe(1'b0, int'($urandom_range(1, 2)));
            if (o_locked === 1'b0) seen_unlock = 1'b1;
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL loss.track strobe %0d: got %h want %h", m_k,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        n_cmp++;
        if (seen_unlock !== 1'b1) begin
            n_bad++;
            $display("[TB] FAIL loss.unlock: got seen_unlock=%b want 1", seen_unlock);
        end
        for (int i = 0; i < 400; i++) begin
            drive_strobe(1'b0, int'($urandom_range(1, 2)));
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL loss.track strobe %0d: got %h want %h", m_k,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        n_cmp++;
        if ({o_locked, o_latency} !== {1'b1, 9'd42} || !(o_bit_cnt > base_bits)) begin
            n_bad++;
            $display("[TB] FAIL loss.relock: got locked=%b lat=%0d bits=%0d want locked=1 lat=42 bits>%0d",
                     o_locked, o_latency, o_bit_cnt, base_bits);
        end
    endtask

    task automatic test_clear();
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_bit   = 1'($urandom);
        @(posedge clk);
        model_clear();
        @(negedge clk);
        i_clear = 1'b0;
        i_valid = 1'b0;
        n_cmp++;
        if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {1'b0, 9'd0, 64'd0, 64'd0}) begin
            n_bad++;
            $display("[TB] FAIL clear.zero: got locked=%b lat=%0d bits=%0d errs=%0d want all 0",
                     o_locked, o_latency, o_bit_cnt, o_err_cnt);
        end
        for (int i = 0; i < 400; i++) begin
            drive_strobe(1'b0, int'($urandom_range(1, 2)));
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL clear.track strobe %0d: got %h want %h", m_k,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        n_cmp++;
        if ({o_locked, o_latency} !== {1'b1, 9'd42}) begin
            n_bad++;
            $display("[TB] FAIL clear.relock: got locked=%b lat=%0d want locked=1 lat=42", o_locked, o_latency);
        end
    endtask

    task automatic test_enable_and_reset();
        i_enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            i_valid = 1'($urandom);
            i_bit   = 1'($urandom);
            @(negedge clk);
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL disabled.hold cycle %0d: got %h want %h", i,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        i_valid  = 1'b0;
        i_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive_strobe(1'b0, 1);
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL reenable.track strobe %0d: got %h want %h", m_k,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        i_valid = 1'b1;
        i_bit   = src_bit();
        pulse_reset();
        i_valid = 1'b0;
        n_cmp++;
        if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {1'b0, 9'd0, 64'd0, 64'd0}) begin
            n_bad++;
            $display("[TB] FAIL midlock_reset.zero: got locked=%b lat=%0d bits=%0d errs=%0d want all 0",
                     o_locked, o_latency, o_bit_cnt, o_err_cnt);
        end
        for (int i = 0; i < 400; i++) begin
            drive_strobe(1'b0, int'($urandom_range(1, 2)));
            n_cmp++;
            if ({o_locked, o_latency, o_bit_cnt, o_err_cnt} !== {m_locked, m_lat, m_bits, m_errs}) begin
                n_bad++;
                $display("[TB] FAIL post_reset.track strobe %0d: got %h want %h", m_k,
                         {o_locked, o_latency, o_bit_cnt, o_err_cnt}, {m_locked, m_lat, m_bits, m_errs});
            end
        end
        n_cmp++;
        if ({o_locked, o_latency} !== {1'b1, 9'd42}) begin
            n_bad++;
            $display("[TB] FAIL post_reset.relock: got locked=%b lat=%0d want locked=1 lat=42", o_locked, o_latency);
        end
    endtask

    // Scenario sequence.
    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        src_delay = 1;
        i_reset   = 1'b1;
        i_enable  = 1'b1;
        i_valid   = 1'b0;
        i_bit     = 1'b0;
        i_clear   = 1'b0;
        build_sequence();
        model_reset();
        @(negedge clk);
        test_reset();
        test_zero_delay();
        test_delay_37();
        test_injected_errors();
        test_loss_of_lock();
        test_clear();
        test_enable_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
